// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared types for the ID/EX stage.
//            - fwd_sel_e        operand source select (register / MEM / WB)
//            - ALU_* opcodes    ALU control encoding, ADD .. PASS-B
//            - id_ex_t          fields held in the ID/EX pipeline register
//            - hit()            producer-to-source RAW match, x0 excluded
//            ID_EX_FORWARD_EN adds the source indices to id_ex_t, because
//            only the forwarding build needs them after capture.
// Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          srca;
        logic          srcb;
        logic [3:0]    alu_ctrl;
`ifdef ID_EX_FORWARD_EN
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
`endif
        logic [AW-1:0] rd;
        logic [DW-1:0] pc;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
    } id_ex_t;

    // A producer can supply a source only if it writes, targets a real
    // register (x0 is hardwired) and the indices match.
    function automatic logic hit(input logic we, input logic [AW-1:0] prod,
                                 input logic [AW-1:0] src);
        return we && (prod != '0) && (prod == src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_if
// Purpose  : Bundle between decode, the ID/EX stage and its consumers.
//            slave  : the ID/EX stage (takes id_*/mem_*/wb_*/hold/flush,
//                     drives ALU operands, ex_* and stall_o)
//            master : the surrounding pipeline / testbench
// Revision : 1.0  initial release
// ============================================================================
interface id_ex_stage_if
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DW,
    parameter int REG_AW     = AW
);
    logic                  hold_i;
    logic                  flush_i;
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_rd1;
    logic [DATA_WIDTH-1:0] id_rd2;
    logic [DATA_WIDTH-1:0] id_imm;
    logic [REG_AW-1:0]     id_rs1;
    logic [REG_AW-1:0]     id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_AW-1:0]     id_rd;
    logic [3:0]            id_alu_ctrl;
    logic                  id_srcA;
    logic                  id_srcB;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_memwrite;
    logic [REG_AW-1:0]     mem_rd;
    logic                  mem_regwrite;
    logic [DATA_WIDTH-1:0] mem_result;
    logic [REG_AW-1:0]     wb_rd;
    logic                  wb_regwrite;
    logic [DATA_WIDTH-1:0] wb_result;
    logic [DATA_WIDTH-1:0] ALUop1;
    logic [DATA_WIDTH-1:0] ALUop2;
    logic [3:0]            ALUctrl;
    logic [DATA_WIDTH-1:0] ex_store_data;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [REG_AW-1:0]     ex_rd;
    logic                  ex_valid;
    logic                  ex_regwrite;
    logic                  ex_memread;
    logic                  ex_memwrite;
    logic                  stall_o;

    modport slave (
        input  hold_i, flush_i, id_valid, id_pc, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_alu_ctrl,
               id_srcA, id_srcB, id_regwrite, id_memread, id_memwrite,
               mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result,
        output ALUop1, ALUop2, ALUctrl, ex_store_data, ex_pc, ex_rd,
               ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall_o
    );

    modport master (
        output hold_i, flush_i, id_valid, id_pc, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_alu_ctrl,
               id_srcA, id_srcB, id_regwrite, id_memread, id_memwrite,
               mem_rd, mem_regwrite, mem_result, wb_rd, wb_regwrite, wb_result,
        input  ALUop1, ALUop2, ALUctrl, ex_store_data, ex_pc, ex_rd,
               ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall_o
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : forward_unit
// Purpose  : Operand source selection for the EX stage. Compares the
//            registered source indices against the EX/MEM and MEM/WB
//            producers; MEM is younger so it wins over WB. Combinational.
// Ports    : i_rs1/i_rs2           registered source indices
//            i_mem_rd/i_mem_regwrite  EX/MEM producer
//            i_wb_rd/i_wb_regwrite    MEM/WB producer
//            o_sel1/o_sel2         fwd_sel_e per operand
// Revision : 1.0  initial release
// ============================================================================
module forward_unit
    import pipeline_pkg::*;
#(
    parameter int REG_AW = AW
) (
    input  wire logic [REG_AW-1:0] i_rs1,
    input  wire logic [REG_AW-1:0] i_rs2,
    input  wire logic [REG_AW-1:0] i_mem_rd,
    input  wire logic              i_mem_regwrite,
    input  wire logic [REG_AW-1:0] i_wb_rd,
    input  wire logic              i_wb_regwrite,
    output fwd_sel_e               o_sel1,
    output fwd_sel_e               o_sel2
);

    always_comb begin
        o_sel1 = FWD_REG;
        o_sel2 = FWD_REG;
        if (hit(i_mem_regwrite, i_mem_rd, i_rs1))     o_sel1 = FWD_MEM;
        else if (hit(i_wb_regwrite, i_wb_rd, i_rs1))  o_sel1 = FWD_WB;
        if (hit(i_mem_regwrite, i_mem_rd, i_rs2))     o_sel2 = FWD_MEM;
        else if (hit(i_wb_regwrite, i_wb_rd, i_rs2))  o_sel2 = FWD_WB;
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with operand forwarding and hazard
//            stall generation; drives the ALU operands/opcode, store data
//            and the control bits for the EX/MEM register.
// Ports    : clk, rst_n (async, active low)
//            bus (id_ex_stage_if.slave): hold_i, flush_i, id_* decode slot,
//            mem_*/wb_* producers, ALUop1/ALUop2/ALUctrl, ex_*, stall_o
// Config   : ID_EX_FORWARD_EN  defined  -> MEM/WB forwarding, stall only on
//                                          load-use
//                              undefined -> no forward muxes, stall on any
//                                          RAW against EX or MEM
//            The WB->ID capture bypass exists in both builds.
// Revision : 1.0  initial release
// ============================================================================
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = DW,
    parameter int REG_AW     = AW
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    id_ex_stage_if.slave bus
);

    id_ex_t                r_q;
    id_ex_t                w_cap;
    logic [DATA_WIDTH-1:0] w_fwd1;
    logic [DATA_WIDTH-1:0] w_fwd2;
    logic [REG_AW-1:0]     w_ex_rd;
    logic                  w_stall;

    assign w_ex_rd = r_q.rd;

    // Capture image. The register file is written in WB in the same cycle
    // it is read here, so a WB producer is folded in at capture time.
    always_comb begin
        w_cap          = '0;
        w_cap.valid    = bus.id_valid;
        w_cap.regwrite = bus.id_valid & bus.id_regwrite;
        w_cap.memread  = bus.id_valid & bus.id_memread;
        w_cap.memwrite = bus.id_valid & bus.id_memwrite;
        w_cap.srca     = bus.id_srcA;
        w_cap.srcb     = bus.id_srcB;
        w_cap.alu_ctrl = bus.id_alu_ctrl;
`ifdef ID_EX_FORWARD_EN
        w_cap.rs1      = bus.id_rs1;
        w_cap.rs2      = bus.id_rs2;
`endif
        w_cap.rd       = bus.id_rd;
        w_cap.pc       = bus.id_pc;
        w_cap.imm      = bus.id_imm;
        w_cap.rd1      = hit(bus.wb_regwrite, bus.wb_rd, bus.id_rs1) ? bus.wb_result : bus.id_rd1;
        w_cap.rd2      = hit(bus.wb_regwrite, bus.wb_rd, bus.id_rs2) ? bus.wb_result : bus.id_rd2;
    end

`ifdef ID_EX_FORWARD_EN
    fwd_sel_e w_sel1;
    fwd_sel_e w_sel2;
    logic     w_load_in_ex;

    forward_unit #(
        .REG_AW (REG_AW)
    ) u_forward_unit (
        .i_rs1          (r_q.rs1),
        .i_rs2          (r_q.rs2),
        .i_mem_rd       (bus.mem_rd),
        .i_mem_regwrite (bus.mem_regwrite),
        .i_wb_rd        (bus.wb_rd),
        .i_wb_regwrite  (bus.wb_regwrite),
        .o_sel1         (w_sel1),
        .o_sel2         (w_sel2)
    );

    always_comb begin
        case (w_sel1)
            FWD_MEM: w_fwd1 = bus.mem_result;
            FWD_WB:  w_fwd1 = bus.wb_result;
            default: w_fwd1 = r_q.rd1;
        endcase
        case (w_sel2)
            FWD_MEM: w_fwd2 = bus.mem_result;
            FWD_WB:  w_fwd2 = bus.wb_result;
            default: w_fwd2 = r_q.rd2;
        endcase
    end

    // Only a load in EX cannot be forwarded in time; everything else is
    // covered by the MEM/WB muxes.
    assign w_load_in_ex = r_q.valid && r_q.memread && (w_ex_rd != '0);
    assign w_stall      = w_load_in_ex && bus.id_valid &&
                          ((bus.id_use_rs1 && (bus.id_rs1 == w_ex_rd)) ||
                           (bus.id_use_rs2 && (bus.id_rs2 == w_ex_rd)));
`else
    logic w_ex_wr;
    logic w_raw1;
    logic w_raw2;

    assign w_fwd1  = r_q.rd1;
    assign w_fwd2  = r_q.rd2;

    // Without forwarding the consumer waits in ID until its producer has
    // reached WB, where the capture bypass picks the value up.
    assign w_ex_wr = r_q.valid && r_q.regwrite;
    assign w_raw1  = bus.id_use_rs1 && (hit(w_ex_wr, w_ex_rd, bus.id_rs1) ||
                                        hit(bus.mem_regwrite, bus.mem_rd, bus.id_rs1));
    assign w_raw2  = bus.id_use_rs2 && (hit(w_ex_wr, w_ex_rd, bus.id_rs2) ||
                                        hit(bus.mem_regwrite, bus.mem_rd, bus.id_rs2));
    assign w_stall = bus.id_valid && (w_raw1 || w_raw2);
`endif

    // Bubbles clear the whole register; only the control bits matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (bus.flush_i) begin
            r_q <= '0;
        end else if (!bus.hold_i) begin
            if (w_stall) r_q <= '0;
            else         r_q <= w_cap;
        end
    end

    assign bus.ALUop1        = r_q.srca ? r_q.pc  : w_fwd1;
    assign bus.ALUop2        = r_q.srcb ? r_q.imm : w_fwd2;
    assign bus.ALUctrl       = r_q.alu_ctrl;
    assign bus.ex_store_data = w_fwd2;
    assign bus.ex_pc         = r_q.pc;
    assign bus.ex_rd         = r_q.rd;
    assign bus.ex_valid      = r_q.valid;
    assign bus.ex_regwrite   = r_q.regwrite;
    assign bus.ex_memread    = r_q.memread;
    assign bus.ex_memwrite   = r_q.memwrite;
    assign bus.stall_o       = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage: directed scenarios and a
//            randomized run against a slot-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;
    import pipeline_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference view of the instruction sitting in EX.
    logic        m_valid, m_rw, m_mr, m_mw, m_sa, m_sb;
    logic [3:0]  m_ctrl;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_pc, m_a, m_b, m_imm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value the EX instruction sees for source register idx.
    function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] captured);
`ifdef ID_EX_FORWARD_EN
        if (idx != 0 && bus.mem_regwrite && bus.mem_rd == idx) return bus.mem_result;
        if (idx != 0 && bus.wb_regwrite  && bus.wb_rd  == idx) return bus.wb_result;
`endif
        return captured;
    endfunction

    function automatic logic in_flight(input logic [4:0] r);
        if (r == 0) return 1'b0;
`ifdef ID_EX_FORWARD_EN
        return m_valid && m_mr && m_rd == r;
`else
        return (m_valid && m_rw && m_rd == r) || (bus.mem_regwrite && bus.mem_rd == r);
`endif
    endfunction

    function automatic logic exp_stall();
        return bus.id_valid && ((bus.id_use_rs1 && in_flight(bus.id_rs1)) ||
                                (bus.id_use_rs2 && in_flight(bus.id_rs2)));
    endfunction

    function automatic logic [31:0] reg_read(input logic [4:0] idx, input logic [31:0] rf);
        if (idx != 0 && bus.wb_regwrite && bus.wb_rd == idx) return bus.wb_result;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_sa = 0; m_sb = 0;
        m_ctrl = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
    endtask

    task automatic model_edge();
        logic st;
        st = exp_stall();
        if (bus.flush_i || (!bus.hold_i && st)) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end else if (!bus.hold_i) begin
            m_valid = bus.id_valid;
            m_rw    = bus.id_valid && bus.id_regwrite;
            m_mr    = bus.id_valid && bus.id_memread;
            m_mw    = bus.id_valid && bus.id_memwrite;
            m_sa    = bus.id_srcA;   m_sb  = bus.id_srcB;
            m_ctrl  = bus.id_alu_ctrl;
            m_rs1   = bus.id_rs1;    m_rs2 = bus.id_rs2;  m_rd = bus.id_rd;
            m_pc    = bus.id_pc;     m_imm = bus.id_imm;
            m_a     = reg_read(bus.id_rs1, bus.id_rd1);
            m_b     = reg_read(bus.id_rs2, bus.id_rd2);
        end
    endtask

    task automatic check_all();
        chk("ex_valid",    bus.ex_valid,    m_valid);
        chk("ex_regwrite", bus.ex_regwrite, m_rw);
        chk("ex_memread",  bus.ex_memread,  m_mr);
        chk("ex_memwrite", bus.ex_memwrite, m_mw);
        chk("stall_o",     bus.stall_o,     exp_stall());
        if (m_valid) begin
            chk("ALUop1",     bus.ALUop1,        m_sa ? m_pc  : src_val(m_rs1, m_a));
            chk("ALUop2",     bus.ALUop2,        m_sb ? m_imm : src_val(m_rs2, m_b));
            chk("store_data", bus.ex_store_data, src_val(m_rs2, m_b));
            chk("ex_pc",      bus.ex_pc,         m_pc);
            chk("ex_rd",      bus.ex_rd,         m_rd);
            chk("ALUctrl",    bus.ALUctrl,       m_ctrl);
        end
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic advance();
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_id();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rd1 = 0; bus.id_rd2 = 0; bus.id_imm = 0;
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
        bus.id_rd = 0; bus.id_alu_ctrl = 0; bus.id_srcA = 0; bus.id_srcB = 0;
        bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
    endtask

    task automatic clr_all();
        clr_id();
        bus.hold_i = 0; bus.flush_i = 0;
        bus.mem_rd = 0; bus.mem_regwrite = 0; bus.mem_result = 0;
        bus.wb_rd = 0;  bus.wb_regwrite = 0;  bus.wb_result = 0;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rd,
                          input logic sb, input logic rw, input logic mr);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_use_rs1 = u1;
        bus.id_rs2 = rs2; bus.id_use_rs2 = u2; bus.id_rd1 = rd1; bus.id_rd2 = rd2;
        bus.id_imm = imm; bus.id_rd = rd; bus.id_alu_ctrl = ALU_ADD; bus.id_srcA = 0;
        bus.id_srcB = sb; bus.id_regwrite = rw; bus.id_memread = mr; bus.id_memwrite = 0;
    endtask

    initial begin
        clr_all();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_ALUop1",   bus.ALUop1,   0);
        chk("rst_ALUop2",   bus.ALUop2,   0);
        chk("rst_ALUctrl",  bus.ALUctrl,  0);
        chk("rst_stall",    bus.stall_o,  0);
        chk("rst_ex_pc",    bus.ex_pc,    0);
        rst_n = 1;
        settle(); advance();

        // Producer x5, then a consumer of x5 (srcB = imm).
        set_id(32'h100, 5'd1, 1, 5'd2, 0, 32'h0, 32'h0, 32'h0, 5'd5, 0, 1, 0);
        settle(); advance();
        set_id(32'h104, 5'd5, 1, 5'd6, 0, 32'hAAAA, 32'h0, 32'h4, 5'd9, 1, 1, 0);
`ifdef ID_EX_FORWARD_EN
        settle(); chk("s2_nostall", bus.stall_o, 0); advance();
        clr_id();
        bus.mem_rd = 5; bus.mem_regwrite = 1; bus.mem_result = 32'h11;
        bus.wb_rd  = 5; bus.wb_regwrite  = 1; bus.wb_result  = 32'h22;
        settle(); chk("s2_mem_over_wb", bus.ALUop1, 32'h11); chk("s2_imm", bus.ALUop2, 32'h4);
        advance();
`else
        settle(); chk("s6_stall_ex", bus.stall_o, 1); advance();
        bus.mem_rd = 5; bus.mem_regwrite = 1; bus.mem_result = 32'h11;
        settle(); chk("s6_stall_mem", bus.stall_o, 1); advance();
        bus.mem_rd = 0; bus.mem_regwrite = 0; bus.mem_result = 0;
        bus.wb_rd  = 5; bus.wb_regwrite  = 1; bus.wb_result  = 32'h22;
        settle(); chk("s6_release", bus.stall_o, 0); advance();
        clr_all();
        settle(); chk("s6_wb_bypass", bus.ALUop1, 32'h22); advance();
`endif

        // x0 is never forwarded nor bypassed.
        clr_all();
        set_id(32'h200, 5'd0, 1, 5'd0, 0, 32'h0, 32'h0, 32'h0, 5'd3, 0, 1, 0);
        bus.mem_rd = 0; bus.mem_regwrite = 1; bus.mem_result = 32'hFF;
        bus.wb_rd  = 0; bus.wb_regwrite  = 1; bus.wb_result  = 32'hEE;
        settle(); advance();
        clr_id();
        settle(); chk("s3_x0_guard", bus.ALUop1, 32'h0); advance();

        // Load-use: LW x7 then ADD using x7 as rs2.
        clr_all();
        set_id(32'h300, 5'd2, 1, 5'd0, 0, 32'h0, 32'h0, 32'h0, 5'd7, 1, 1, 1);
        settle(); advance();
        set_id(32'h304, 5'd3, 1, 5'd7, 1, 32'h5, 32'hDEAD, 32'h0, 5'd8, 0, 1, 0);
        settle(); chk("s4_stall", bus.stall_o, 1); advance();
`ifdef ID_EX_FORWARD_EN
        settle(); chk("s4_bubble", bus.ex_valid, 0); chk("s4_unstall", bus.stall_o, 0); advance();
        clr_id();
        bus.mem_rd = 7; bus.mem_regwrite = 1; bus.mem_result = 32'h1234;
        settle(); chk("s4_fwd_op2", bus.ALUop2, 32'h1234); chk("s4_fwd_store", bus.ex_store_data, 32'h1234);
        advance();
`else
        bus.mem_rd = 7; bus.mem_regwrite = 1; bus.mem_result = 32'h0;
        settle(); chk("s4_bubble", bus.ex_valid, 0); chk("s4_stall_mem", bus.stall_o, 1); advance();
        bus.mem_rd = 0; bus.mem_regwrite = 0;
        bus.wb_rd  = 7; bus.wb_regwrite  = 1; bus.wb_result = 32'h1234;
        settle(); chk("s4_unstall", bus.stall_o, 0); advance();
        clr_all();
        settle(); chk("s4_fwd_op2", bus.ALUop2, 32'h1234); advance();
`endif

        // Flush beats hold; then hold alone freezes the slot.
        clr_all();
        set_id(32'h400, 5'd1, 0, 5'd2, 0, 32'h0, 32'h0, 32'h0, 5'd4, 0, 1, 0);
        settle(); advance();
        set_id(32'h500, 5'd1, 0, 5'd2, 0, 32'h0, 32'h0, 32'h0, 5'd6, 0, 1, 0);
        bus.hold_i = 1; bus.flush_i = 1;
        settle(); advance();
        bus.hold_i = 0; bus.flush_i = 0;
        set_id(32'h600, 5'd1, 0, 5'd2, 0, 32'h0, 32'h0, 32'h0, 5'd10, 0, 1, 0);
        settle(); chk("s5_flush_hold", bus.ex_valid, 0); advance();
        for (int i = 0; i < 3; i++) begin
            set_id($urandom, 5'($urandom_range(0, 31)), 1, 5'($urandom_range(0, 31)), 1,
                   $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), 0, 1, 1);
            bus.hold_i = 1;
            settle();
            chk("s5_hold_pc", bus.ex_pc, 32'h600);
            chk("s5_hold_rd", bus.ex_rd, 5'd10);
            chk("s5_hold_valid", bus.ex_valid, 1);
            advance();
        end

        // Asynchronous reset between edges.
        clr_all();
        rst_n = 0;
        settle();
        chk("s1_rst_valid", bus.ex_valid, 0);
        chk("s1_rst_op1",   bus.ALUop1,   0);
        chk("s1_rst_op2",   bus.ALUop2,   0);
        chk("s1_rst_stall", bus.stall_o,  0);
        model_reset();
        rst_n = 1;
        advance();

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            clr_id();
            if ($urandom_range(0, 3) != 0) begin
                bus.id_valid    = 1;
                bus.id_regwrite = 1'($urandom);
                bus.id_memread  = 1'($urandom);
                bus.id_memwrite = 1'($urandom);
            end
            bus.id_pc        = $urandom;
            bus.id_rd1       = $urandom;
            bus.id_rd2       = $urandom;
            bus.id_imm       = $urandom;
            bus.id_rs1       = 5'($urandom_range(0, 3));
            bus.id_rs2       = 5'($urandom_range(0, 3));
            bus.id_use_rs1   = 1'($urandom);
            bus.id_use_rs2   = 1'($urandom);
            bus.id_rd        = 5'($urandom_range(0, 3));
            bus.id_alu_ctrl  = 4'($urandom_range(0, 10));
            bus.id_srcA      = 1'($urandom);
            bus.id_srcB      = 1'($urandom);
            bus.hold_i       = ($urandom_range(0, 7) == 0);
            bus.flush_i      = ($urandom_range(0, 9) == 0);
            bus.mem_rd       = 5'($urandom_range(0, 3));
            bus.mem_regwrite = 1'($urandom);
            bus.mem_result   = $urandom;
            bus.wb_rd        = 5'($urandom_range(0, 3));
            bus.wb_regwrite  = 1'($urandom);
            bus.wb_result    = $urandom;
            settle();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
